io_bus_arbiter: RTL and testbench
=================================

Name: io_bus_arbiter

Overview:
- Shares the single memory-mapped IO bus (addresses 0x0002_0000 and above) between two masters.
- Master 0 is the processor's IO port. Master 1 is a DMA/boot-loader engine.
- Selects one owner per cycle, routes its address, data and enables to the peripheral side, and returns read data only to the owner.
- The non-owner sees a wait flag; the processor uses its wait flag to hold the PC.

Parameters:
- ADDR_W, 32, address width of masters and slave.
- DATA_W, 32, read/write data width.
- MAX_HOLD, 8, consecutive granted cycles an owner may keep the bus while the other master waits (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_addr  in  ADDR_W  master 0 address.
- m0_wr_val  in  DATA_W  master 0 write data.
- m0_write_en  in  1  master 0 write strobe.
- m0_read_en  in  1  master 0 read strobe.
- m0_data_size  in  3  master 0 access size (funct3 encoding).
- m0_rd_val  out  DATA_W  read data to master 0.
- m0_wait  out  1  master 0 requesting but not granted.
- m1_addr, m1_wr_val, m1_write_en, m1_read_en, m1_data_size  in  same widths as m0  master 1 request.
- m1_lock  in  1  master 1 burst lock.
- m1_rd_val  out  DATA_W  read data to master 1.
- m1_wait  out  1  master 1 requesting but not granted.
- s_addr  out  ADDR_W  peripheral address.
- s_wr_val  out  DATA_W  peripheral write data.
- s_write_en  out  1  peripheral write strobe.
- s_read_en  out  1  peripheral read strobe.
- s_data_size  out  3  peripheral access size.
- s_rd_val  in  DATA_W  peripheral read data (combinational, same cycle).
- gnt  out  2  one-hot current owner, bit0 = m0.
- contention_cnt  out  16  cycles in which any master waited (optional feature).

Behaviour:
- Request: mN_req = mN_write_en | mN_read_en.
- States: PARK, OWN0, OWN1. State, hold counter and contention counter are registered; everything else is combinational from state and inputs.
- Reset (rst_n low, async):
  - state = PARK, hold_cnt = 0, contention_cnt = 0.
  - gnt = 2'b01.
  - s_write_en = s_read_en = 0, forced low while rst_n is low.
  - m0_wait = m1_wait = 0; both rd_val outputs = 0.
- PARK: the bus is parked on m0 (gnt = 01), so m0 has zero-latency access.
  - m0_req, no m1_req: stay PARK.
  - m1_req and m0_req: stay PARK, m1_wait = 1, hold_cnt increments.
  - m1_req, no m0_req: next = OWN1. m1_wait = 1 this cycle; first m1 access is the following cycle.
  - hold_cnt reaching MAX_HOLD with m1 still waiting: next = OWN1, hold_cnt = 0.
- OWN1: gnt = 10.
  - m1_req low: next = PARK.
  - m0 waiting, hold_cnt reaches MAX_HOLD, m1_lock low: next = OWN0, hold_cnt = 0.
  - m1_lock high: overrides MAX_HOLD; hold_cnt saturates at MAX_HOLD.
- OWN0: gnt = 01.
  - Entered only by preemption of m1.
  - m0_req low: next = PARK.
  - m1 waiting at MAX_HOLD: next = OWN1.
- hold_cnt clears whenever the non-owner is not requesting or the owner changes.
- Routing:
  - s_* = owner's fields; s_write_en/s_read_en = owner's strobes.
  - Owner's rd_val = s_rd_val; non-owner's rd_val = 0.
  - The non-owner's strobes never reach the slave.
- Wait: mN_wait = mN_req & !gnt[N], combinational.
- Grant changes only on clk rising edge; never mid-cycle.
- Reset mid-transfer: the strobe drops immediately; no partial-cycle write is guaranteed, and the owner reissues after reset.

Optional Feature:
- Macro IO_ARB_CONTENTION_CNT_EN.
- Defined: contention_cnt increments each cycle (m0_wait | m1_wait), saturates at 0xFFFF, clears only on reset.
- Undefined: contention_cnt tied to 0 and no counter flops are built.

Decomposition:
- Package io_arb_pkg holds:
  - state enum (PARK, OWN0, OWN1);
  - master index constants M0 = 0, M1 = 1;
  - the IO region base constant 0x0002_0000;
  - the hold-counter width localparam.
- One sub-module, io_arb_hold_counter: MAX_HOLD-bounded saturating counter with clear/inc/expired outputs.

Test Plan:
- Reset with rst_n low while m0_write_en = 1: s_write_en = 0 and gnt = 01. Release rst_n: s_write_en follows m0 in the same cycle, m0_wait = 0.
- m1 alone reads 0x0003_0000 from PARK: cycle 0 m1_wait = 1; cycle 1 gnt = 10, s_addr = 0x0003_0000, m1_rd_val = s_rd_val, m0_rd_val = 0.
- Both request continuously with MAX_HOLD = 4: ownership alternates every 4 cycles. No master waits more than 4 consecutive cycles; contention_cnt increments every cycle.
- m1_lock = 1 with both requesting for 20 cycles: gnt stays 10 for all 20 cycles and m0_wait = 1 throughout. Drop the lock: gnt = 01 on the next edge.
- Simultaneous request in PARK with m1 write 0xDEADBEEF: m0 is served first; the m1 write reaches s_wr_val only after preemption, and no m1 strobe appears on s_* before gnt = 10.
- Assert rst_n low during an OWN1 burst: outputs reach reset values asynchronously, before the next clk edge. contention_cnt = 0 (feature on) or stays 0 (feature off).

Source files
------------

// File: rtl/io_arb_pkg.sv
// Shared types and constants for the IO bus arbiter.
// The optional contention counter is enabled with IO_ARB_CONTENTION_CNT_EN.
package io_arb_pkg;

  typedef enum logic [1:0] {
    PARK = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int M0 = 0;
  localparam int M1 = 1;

  localparam logic [31:0] IO_BASE = 32'h0002_0000;

  // Wide enough for MAX_HOLD up to 255.
  localparam int HOLD_W = 8;

endpackage

// File: rtl/io_arb_hold_counter.sv
// Counts consecutive cycles the non-owner waits; saturates at MAX_HOLD and
// flags expiry on the cycle the wait reaches MAX_HOLD.
module io_arb_hold_counter
  import io_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [HOLD_W-1:0] cnt,
  output logic              expired
);

  localparam logic [HOLD_W-1:0] LIMIT = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] LAST  = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] cnt_r;

  // Expired stays asserted once saturated so a released lock hands over at once.
  assign expired = inc & (cnt_r >= LAST);
  assign cnt     = cnt_r;

  // Saturating wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {HOLD_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {HOLD_W{1'b0}};
    end else if (inc && (cnt_r < LIMIT)) begin
      cnt_r <= cnt_r + HOLD_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master arbiter for the memory-mapped IO bus, parked on master 0.
// Define IO_ARB_CONTENTION_CNT_EN to build the contention counter.
module io_bus_arbiter
  import io_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_val,
  input  logic              m0_write_en,
  input  logic              m0_read_en,
  input  logic [2:0]        m0_data_size,
  output logic [DATA_W-1:0] m0_rd_val,
  output logic              m0_wait,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_val,
  input  logic              m1_write_en,
  input  logic              m1_read_en,
  input  logic [2:0]        m1_data_size,
  input  logic              m1_lock,
  output logic [DATA_W-1:0] m1_rd_val,
  output logic              m1_wait,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wr_val,
  output logic              s_write_en,
  output logic              s_read_en,
  output logic [2:0]        s_data_size,
  input  logic [DATA_W-1:0] s_rd_val,
  output logic [1:0]        gnt,
  output logic [15:0]       contention_cnt
);

  arb_state_e        state_r;
  arb_state_e        next_s;
  logic              m0_req_s;
  logic              m1_req_s;
  logic              own1_s;
  logic              waiting_s;
  logic              hold_clr_s;
  logic              expired_s;
  logic [HOLD_W-1:0] hold_cnt_s;

  assign m0_req_s  = m0_write_en | m0_read_en;
  assign m1_req_s  = m1_write_en | m1_read_en;
  assign own1_s    = (state_r == OWN1);
  assign waiting_s = own1_s ? m0_req_s : m1_req_s;

  // Any ownership change restarts the fairness window.
  assign hold_clr_s = ~waiting_s | (next_s != state_r);

  io_arb_hold_counter #(
    .MAX_HOLD(MAX_HOLD)
  ) u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (hold_clr_s),
    .inc    (waiting_s),
    .cnt    (hold_cnt_s),
    .expired(expired_s)
  );

  // Next-owner selection.
  always_comb begin
    next_s = state_r;
    case (state_r)
      PARK: begin
        if (m1_req_s && !m0_req_s) begin
          next_s = OWN1;
        end else if (expired_s) begin
          next_s = OWN1;
        end else begin
          next_s = PARK;
        end
      end
      OWN1: begin
        if (!m1_req_s) begin
          next_s = PARK;
        end else if (expired_s && !m1_lock) begin
          next_s = OWN0;
        end else begin
          next_s = OWN1;
        end
      end
      OWN0: begin
        if (!m0_req_s) begin
          next_s = PARK;
        end else if (expired_s) begin
          next_s = OWN1;
        end else begin
          next_s = OWN0;
        end
      end
      default: next_s = PARK;
    endcase
  end

  // Ownership register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= PARK;
    end else begin
      state_r <= next_s;
    end
  end

  assign gnt[M0] = ~own1_s;
  assign gnt[M1] = own1_s;

  // Owner routing; strobes and returned data are squashed while in reset.
  always_comb begin
    s_addr      = m0_addr;
    s_wr_val    = m0_wr_val;
    s_data_size = m0_data_size;
    s_write_en  = 1'b0;
    s_read_en   = 1'b0;
    m0_rd_val   = {DATA_W{1'b0}};
    m1_rd_val   = {DATA_W{1'b0}};
    if (own1_s) begin
      s_addr      = m1_addr;
      s_wr_val    = m1_wr_val;
      s_data_size = m1_data_size;
      s_write_en  = m1_write_en & rst_n;
      s_read_en   = m1_read_en & rst_n;
      m1_rd_val   = rst_n ? s_rd_val : {DATA_W{1'b0}};
    end else begin
      s_write_en  = m0_write_en & rst_n;
      s_read_en   = m0_read_en & rst_n;
      m0_rd_val   = rst_n ? s_rd_val : {DATA_W{1'b0}};
    end
  end

  assign m0_wait = m0_req_s & ~gnt[M0] & rst_n;
  assign m1_wait = m1_req_s & ~gnt[M1] & rst_n;

`ifdef IO_ARB_CONTENTION_CNT_EN
  logic [15:0] contention_r;

  // Saturating count of cycles in which someone waited.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contention_r <= 16'h0000;
    end else if ((m0_wait | m1_wait) && (contention_r != 16'hFFFF)) begin
      contention_r <= contention_r + 16'h0001;
    end else begin
      contention_r <= contention_r;
    end
  end

  assign contention_cnt = contention_r;
`else
  assign contention_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed and randomized bench for io_bus_arbiter with a cycle-level owner model.
module tb_io_bus_arbiter;
  import io_arb_pkg::*;

  localparam int MAXH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] m0_addr = 32'h0, m0_wr_val = 32'h0, m0_rd_val;
  logic        m0_write_en = 1'b0, m0_read_en = 1'b0, m0_wait;
  logic [2:0]  m0_data_size = 3'd0;
  logic [31:0] m1_addr = 32'h0, m1_wr_val = 32'h0, m1_rd_val;
  logic        m1_write_en = 1'b0, m1_read_en = 1'b0, m1_wait, m1_lock = 1'b0;
  logic [2:0]  m1_data_size = 3'd0;
  logic [31:0] s_addr, s_wr_val, s_rd_val = 32'h0;
  logic        s_write_en, s_read_en;
  logic [2:0]  s_data_size;
  logic [1:0]  gnt;
  logic [15:0] contention_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: current owner, whether the bus is merely parked on m0,
  // consecutive wait cycles of the other master, and contention total.
  int owner  = 0;
  bit parked = 1'b1;
  int streak = 0;
  int cont   = 0;

  always #5 clk = ~clk;

  io_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m0_wr_val(m0_wr_val), .m0_write_en(m0_write_en),
    .m0_read_en(m0_read_en), .m0_data_size(m0_data_size),
    .m0_rd_val(m0_rd_val), .m0_wait(m0_wait),
    .m1_addr(m1_addr), .m1_wr_val(m1_wr_val), .m1_write_en(m1_write_en),
    .m1_read_en(m1_read_en), .m1_data_size(m1_data_size), .m1_lock(m1_lock),
    .m1_rd_val(m1_rd_val), .m1_wait(m1_wait),
    .s_addr(s_addr), .s_wr_val(s_wr_val), .s_write_en(s_write_en),
    .s_read_en(s_read_en), .s_data_size(s_data_size), .s_rd_val(s_rd_val),
    .gnt(gnt), .contention_cnt(contention_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = 0; parked = 1'b1; streak = 0; cont = 0;
  endtask

  task automatic check_outputs(input string tag);
    bit r0, r1, own1;
    logic [31:0] exp_cont;
    r0 = m0_write_en | m0_read_en;
    r1 = m1_write_en | m1_read_en;
    own1 = (owner == 1);
`ifdef IO_ARB_CONTENTION_CNT_EN
    exp_cont = 32'(cont);
`else
    exp_cont = 32'h0;
`endif
    chk({tag, ".gnt"}, {30'h0, gnt}, own1 ? 32'h2 : 32'h1);
    chk({tag, ".m0_wait"}, {31'h0, m0_wait}, {31'h0, r0 && own1});
    chk({tag, ".m1_wait"}, {31'h0, m1_wait}, {31'h0, r1 && !own1});
    chk({tag, ".s_addr"}, s_addr, own1 ? m1_addr : m0_addr);
    chk({tag, ".s_wr_val"}, s_wr_val, own1 ? m1_wr_val : m0_wr_val);
    chk({tag, ".s_size"}, {29'h0, s_data_size}, {29'h0, own1 ? m1_data_size : m0_data_size});
    chk({tag, ".s_we"}, {31'h0, s_write_en}, {31'h0, own1 ? m1_write_en : m0_write_en});
    chk({tag, ".s_re"}, {31'h0, s_read_en}, {31'h0, own1 ? m1_read_en : m0_read_en});
    chk({tag, ".m0_rd"}, m0_rd_val, own1 ? 32'h0 : s_rd_val);
    chk({tag, ".m1_rd"}, m1_rd_val, own1 ? s_rd_val : 32'h0);
    chk({tag, ".cont"}, {16'h0, contention_cnt}, exp_cont);
  endtask

  // Apply the arbitration rules for one clock edge.
  task automatic model_edge();
    bit r0, r1;
    int ow;
    r0 = m0_write_en | m0_read_en;
    r1 = m1_write_en | m1_read_en;
    ow = owner;
    if (((r0 && ow != 0) || (r1 && ow != 1)) && cont < 65535) cont++;
    if (!(ow == 0 ? r0 : r1)) begin
      if (parked && r1) begin owner = 1; parked = 1'b0; end
      else begin owner = 0; parked = 1'b1; end
      streak = 0;
    end else if (ow == 0 ? r1 : r0) begin
      streak = (streak < MAXH) ? streak + 1 : MAXH;
      if (streak >= MAXH && !(ow == 1 && m1_lock)) begin
        owner = 1 - ow; parked = 1'b0; streak = 0;
      end
    end else begin
      streak = 0;
    end
  endtask

  task automatic sample(input string tag);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_m0(input bit we, input bit re, input logic [31:0] a, input logic [31:0] d);
    m0_write_en = we; m0_read_en = re; m0_addr = a; m0_wr_val = d; m0_data_size = 3'd2;
  endtask

  task automatic set_m1(input bit we, input bit re, input logic [31:0] a, input logic [31:0] d);
    m1_write_en = we; m1_read_en = re; m1_addr = a; m1_wr_val = d; m1_data_size = 3'd2;
  endtask

  initial begin
    int run0, run1;
    // Reset held with m0 writing.
    set_m0(1'b1, 1'b0, IO_BASE + 32'h10, 32'hA5A5_0001);
    s_rd_val = 32'h1234_5678;
    #1 rst_n = 1'b0;
    #2;
    chk("rst.s_we", {31'h0, s_write_en}, 32'h0);
    chk("rst.gnt", {30'h0, gnt}, 32'h1);
    chk("rst.m0_rd", m0_rd_val, 32'h0);
    chk("rst.m0_wait", {31'h0, m0_wait}, 32'h0);
    @(posedge clk); #1;
    chk("rst_hold.s_we", {31'h0, s_write_en}, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rel.s_we", {31'h0, s_write_en}, 32'h1);
    chk("rel.m0_wait", {31'h0, m0_wait}, 32'h0);
    model_reset();
    sample("rel");
    advance();

    // m1 alone reads from PARK.
    set_m0(1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b1, 32'h0003_0000, 32'h0);
    s_rd_val = 32'hCAFE_0042;
    sample("m1a0");
    chk("m1a0.wait", {31'h0, m1_wait}, 32'h1);
    advance();
    sample("m1a1");
    chk("m1a1.gnt", {30'h0, gnt}, 32'h2);
    chk("m1a1.addr", s_addr, 32'h0003_0000);
    chk("m1a1.rd", m1_rd_val, 32'hCAFE_0042);
    advance();

    // Both request continuously: alternation and bounded waits.
    set_m0(1'b0, 1'b1, IO_BASE + 32'h20, 32'h0);
    set_m1(1'b1, 1'b0, IO_BASE + 32'h40, 32'h5555_AAAA);
    run0 = 0; run1 = 0;
    for (int i = 0; i < 24; i++) begin
      s_rd_val = $urandom;
      sample("both");
      run0 = m0_wait ? run0 + 1 : 0;
      run1 = m1_wait ? run1 + 1 : 0;
      chk("both.run0", {31'h0, run0 <= MAXH}, 32'h1);
      chk("both.run1", {31'h0, run1 <= MAXH}, 32'h1);
      advance();
    end

    // Locked burst holds the bus regardless of m0.
    set_m0(1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0);
    sample("idle"); advance();
    sample("idle"); advance();
    m1_lock = 1'b1;
    set_m1(1'b1, 1'b0, IO_BASE + 32'h100, 32'h0BAD_F00D);
    sample("lk0"); advance();
    set_m0(1'b1, 1'b0, IO_BASE + 32'h200, 32'h7777_0000);
    for (int i = 0; i < 20; i++) begin
      sample("lk");
      chk("lk.gnt", {30'h0, gnt}, 32'h2);
      chk("lk.m0_wait", {31'h0, m0_wait}, 32'h1);
      advance();
    end
    m1_lock = 1'b0;
    sample("unlk"); advance();
    sample("unlk1");
    chk("unlk1.gnt", {30'h0, gnt}, 32'h1);
    advance();

    // Simultaneous request in PARK: m0 first, m1 write only after preemption.
    set_m0(1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0);
    sample("idle2"); advance();
    sample("idle2"); advance();
    set_m0(1'b1, 1'b0, IO_BASE + 32'h4, 32'h1111_2222);
    set_m1(1'b1, 1'b0, IO_BASE + 32'h8, 32'hDEAD_BEEF);
    for (int i = 0; i < MAXH; i++) begin
      sample("sim");
      chk("sim.s_wr", s_wr_val, 32'h1111_2222);
      advance();
    end
    sample("sim_pre");
    chk("sim_pre.gnt", {30'h0, gnt}, 32'h2);
    chk("sim_pre.s_wr", s_wr_val, 32'hDEAD_BEEF);

    // Asynchronous reset in the middle of the m1 burst.
    rst_n = 1'b0;
    #1;
    chk("arst.s_we", {31'h0, s_write_en}, 32'h0);
    chk("arst.gnt", {30'h0, gnt}, 32'h1);
    chk("arst.m0_wait", {31'h0, m0_wait}, 32'h0);
    chk("arst.m1_rd", m1_rd_val, 32'h0);
    chk("arst.cont", {16'h0, contention_cnt}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    advance();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      set_m0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), IO_BASE + $urandom_range(0, 255), $urandom);
      set_m1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), IO_BASE + $urandom_range(0, 255), $urandom);
      m0_data_size = 3'($urandom_range(0, 7));
      m1_data_size = 3'($urandom_range(0, 7));
      m1_lock = ($urandom_range(0, 3) == 0);
      s_rd_val = $urandom;
      sample("rnd");
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
